// File: rtl/logic_gate_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_arbiter_pkg
//  Description : Shared types and constants for the two-requester arbiter
//                that time-shares one external logic-gate unit.
//  Revision    : 1.0  initial release
// ============================================================================
package logic_gate_arbiter_pkg;

  // Width of the settle counter; holds SETTLE_CYCLES-1 for SETTLE_CYCLES up to 15.
  localparam int unsigned SETTLE_W = 4;

  // Gate select codes presented by requesters and driven to the shared unit.
  localparam logic [2:0] GATE_AND     = 3'b000;
  localparam logic [2:0] GATE_OR      = 3'b001;
  localparam logic [2:0] GATE_NOT     = 3'b010;
  localparam logic [2:0] GATE_NAND    = 3'b011;
  localparam logic [2:0] GATE_NOR     = 3'b100;
  localparam logic [2:0] GATE_XOR     = 3'b101;
  localparam logic [2:0] GATE_XNOR    = 3'b110;
  localparam logic [2:0] GATE_ILLEGAL = 3'b111;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage : logic_gate_arbiter_pkg
`default_nettype wire

// File: rtl/logic_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_arbiter_if
//  Description : Request/response handshakes for both requesters plus the
//                connection to the shared logic-gate unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface logic_gate_arbiter_if;

  logic       req0_valid;
  logic       req0_ready;
  logic       req0_a;
  logic       req0_b;
  logic [2:0] req0_gate;
  logic       req1_valid;
  logic       req1_ready;
  logic       req1_a;
  logic       req1_b;
  logic [2:0] req1_gate;

  logic       resp0_valid;
  logic       resp0_ready;
  logic       resp0_o;
  logic       resp0_err;
  logic       resp1_valid;
  logic       resp1_ready;
  logic       resp1_o;
  logic       resp1_err;

  logic       gate_a;
  logic       gate_b;
  logic [2:0] gate_type;
  logic       gate_o;

  logic       busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_gate,
    input  req1_valid, req1_a, req1_b, req1_gate,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_o, resp0_err,
    output resp1_valid, resp1_o, resp1_err,
    input  resp0_ready, resp1_ready,
    output gate_a, gate_b, gate_type,
    input  gate_o,
    output busy
  );

  // Requester / environment side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_gate,
    output req1_valid, req1_a, req1_b, req1_gate,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_o, resp0_err,
    input  resp1_valid, resp1_o, resp1_err,
    output resp0_ready, resp1_ready,
    input  gate_a, gate_b, gate_type,
    output gate_o,
    input  busy
  );

endinterface : logic_gate_arbiter_if
`default_nettype wire

// File: rtl/logic_gate_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant. A lone requester always wins;
//                under contention the requester not granted last time wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
  input  wire logic [1:0] valid,
  input  wire logic       last_grant,
  output logic            grant
);

  // Purely combinational pick; with no requester the value is don't-care, 0 is used.
  always_comb begin
    grant = 1'b0;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/logic_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_arbiter
//  Description : Shares one combinational logic-gate unit between two
//                requesters. Accepts one operation at a time, holds the
//                operands on the unit for SETTLE_CYCLES, captures the result
//                and returns it to the winning requester with backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_gate_arbiter
  import logic_gate_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  logic_gate_arbiter_if.slave  bus
);

  localparam logic [SETTLE_W-1:0] c_cnt_load = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] c_cnt_one  = SETTLE_W'(1);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic [2:0]          gate_q, gate_d;
  logic                result_q, result_d;
  logic                err_q, err_d;

  logic                w_arb_grant;
  logic                w_req0_ready;
  logic                w_req1_ready;
  logic                w_winner_resp_ready;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (w_arb_grant)
  );

  assign w_winner_resp_ready = grant_q ? bus.resp1_ready : bus.resp0_ready;

  // Next-state, operand latching and handshake generation for the sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    gate_d       = gate_q;
    result_d     = result_q;
    err_d        = err_q;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        w_req0_ready = bus.req0_valid && (w_arb_grant == 1'b0);
        w_req1_ready = bus.req1_valid && (w_arb_grant == 1'b1);
        if (w_req0_ready || w_req1_ready) begin
          grant_d      = w_arb_grant;
          last_grant_d = w_arb_grant;
          a_d          = w_arb_grant ? bus.req1_a    : bus.req0_a;
          b_d          = w_arb_grant ? bus.req1_b    : bus.req0_b;
          gate_d       = w_arb_grant ? bus.req1_gate : bus.req0_gate;
          cnt_d        = c_cnt_load;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      CAPTURE: begin
        // The illegal code never trusts the unit's output.
        if (gate_q == GATE_ILLEGAL) begin
          result_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          result_d = bus.gate_o;
          err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (w_winner_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      gate_q       <= 3'b000;
      result_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      gate_q       <= gate_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // Operand registers only change on acceptance, so they naturally hold
  // their last values through IDLE and RESP.
  assign bus.gate_a      = a_q;
  assign bus.gate_b      = b_q;
  assign bus.gate_type   = gate_q;

  assign bus.req0_ready  = w_req0_ready;
  assign bus.req1_ready  = w_req1_ready;

  assign bus.resp0_valid = (state_q == RESP) && !grant_q;
  assign bus.resp1_valid = (state_q == RESP) &&  grant_q;
  assign bus.resp0_o     = bus.resp0_valid & result_q;
  assign bus.resp0_err   = bus.resp0_valid & err_q;
  assign bus.resp1_o     = bus.resp1_valid & result_q;
  assign bus.resp1_err   = bus.resp1_valid & err_q;

  assign bus.busy        = (state_q != IDLE);

endmodule : logic_gate_arbiter
`default_nettype wire
